sync_counter_param: RTL and testbench

Parametrised synchronous up/down counter. It is the successor to the fixed 8-bit enable/reset LED counter. It adds configurable width and modulus, direction control, parallel load, and wrap or saturate mode. It also adds terminal-count and wrap flags. The block sits between the board switch inputs and the LED outputs, and is also reusable as a general event counter inside larger designs.

---
 rtl/counter_pkg.sv | 17 +
 rtl/step_sync_edge.sv | 26 ++
 rtl/sync_counter_param.sv | 90 +++++++++
 tb/tb_sync_counter_param.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for sync_counter_param: direction encodings, load clamping
// and the MODULUS legality check used at elaboration.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic longint unsigned clamp_load(input longint unsigned val,
                                                 input longint unsigned modulus);
    return (val >= modulus) ? (modulus - 64'd1) : val;
  endfunction

  function automatic bit modulus_legal(input int width, input longint modulus);
    return (modulus >= 2) && (modulus <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/step_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous STEP input;
// pulse is high for one cycle per rising edge of din.
module step_sync_edge (
  input  logic CLK100MHZ,
  input  logic RST,
  input  logic din,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/sync_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate and TC/WRAP flags.
// Define STEP_EDGE_DETECT_EN to treat STEP as an asynchronous edge-counted input.
module sync_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             EN,
  input  logic             STEP,
  input  logic             UP_DN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             WRAP
);

  if (!modulus_legal(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
    $error("sync_counter_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // One extra bit so MODULUS-1 and +1 are representable when MODULUS == 2**WIDTH
  localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   countExt;
  logic [WIDTH-1:0] loadClamped;
  logic             stepEvent;
  logic             tick;

`ifdef STEP_EDGE_DETECT_EN
  step_sync_edge u_step_sync_edge (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .din       (STEP),
    .pulse     (stepEvent)
  );
`else
  assign stepEvent = STEP;
`endif

  assign tick        = EN & stepEvent;
  assign countExt    = {1'b0, count_q};
  assign loadClamped = WIDTH'(clamp_load(64'(LOAD_VAL), 64'(MODULUS)));

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (LOAD) begin
      count_d = loadClamped;
    end else if (tick) begin
      if (UP_DN == DIR_UP) begin
        if (countExt == MAX_C) begin
          wrap_d = 1'b1;
          if (!SATURATE) count_d = '0;
        end else begin
          count_d = WIDTH'(countExt + 1'b1);
        end
      end else begin
        if (countExt == '0) begin
          wrap_d = 1'b1;
          if (!SATURATE) count_d = MAX_C[WIDTH-1:0];
        end else begin
          count_d = WIDTH'(countExt - 1'b1);
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign COUNT = count_q;
  assign WRAP  = wrap_q;
  assign TC    = ((UP_DN == DIR_UP)   && (countExt == MAX_C)) ||
                 ((UP_DN == DIR_DOWN) && (countExt == '0));

endmodule

// File: tb/tb_sync_counter_param.sv
// Self-checking bench for sync_counter_param: three instances (wrap, saturate,
// full-range modulus) share stimulus and are checked against a reference model.
module tb_sync_counter_param;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       step;
    logic       up;
    logic       load;
    logic [7:0] lv;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [7:0] expCount;
    logic       expWrap;
  } vec_t;

  typedef struct packed {
    logic [2:0][7:0] cnt;
    logic [2:0]      wrap;
    logic [2:0]      tc;
  } exp_t;

`ifdef STEP_EDGE_DETECT_EN
  localparam int HELD_INCS = 1;
`else
  localparam int HELD_INCS = 50;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, step = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] lv = 8'd0;
  logic [7:0] countW, countS;
  logic [3:0] countF;
  logic       tcW, tcS, tcF, wrapW, wrapS, wrapF;

  int   assertCount = 0;
  int   failCount   = 0;
  exp_t scoreboard[$];

  int modelCnt [3];
  bit modelSync1, modelSync2, modelPrev;
  int modelMod [3] = '{10, 10, 16};
  bit modelSat [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  sync_counter_param #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b0)) dutWrap (
    .CLK100MHZ(clk), .RST(rst), .EN(en), .STEP(step), .UP_DN(up), .LOAD(load),
    .LOAD_VAL(lv), .COUNT(countW), .TC(tcW), .WRAP(wrapW));

  sync_counter_param #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b1)) dutSat (
    .CLK100MHZ(clk), .RST(rst), .EN(en), .STEP(step), .UP_DN(up), .LOAD(load),
    .LOAD_VAL(lv), .COUNT(countS), .TC(tcS), .WRAP(wrapS));

  sync_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dutFull (
    .CLK100MHZ(clk), .RST(rst), .EN(en), .STEP(step), .UP_DN(up), .LOAD(load),
    .LOAD_VAL(lv[3:0]), .COUNT(countF), .TC(tcF), .WRAP(wrapF));

  function automatic stim_t mk(input logic r, input logic e, input logic st,
                               input logic u, input logic l, input logic [7:0] v);
    stim_t s;
    s.rst = r; s.en = e; s.step = st; s.up = u; s.load = l; s.lv = v;
    return s;
  endfunction

  // Reference model: advances the expected state by one rising edge.
  task automatic modelEdge(input stim_t s, output exp_t e);
    bit evt;
    int v;
`ifdef STEP_EDGE_DETECT_EN
    evt = modelSync2 & ~modelPrev;
`else
    evt = s.step;
`endif
    e = '0;
    for (int i = 0; i < 3; i++) begin
      if (s.rst) begin
        modelCnt[i] = 0;
      end else if (s.load) begin
        v = (i == 2) ? int'(s.lv[3:0]) : int'(s.lv);
        modelCnt[i] = (v >= modelMod[i]) ? modelMod[i] - 1 : v;
      end else if (s.en && evt) begin
        if (s.up) begin
          if (modelCnt[i] == modelMod[i] - 1) begin
            e.wrap[i] = 1'b1;
            if (!modelSat[i]) modelCnt[i] = 0;
          end else modelCnt[i] = modelCnt[i] + 1;
        end else begin
          if (modelCnt[i] == 0) begin
            e.wrap[i] = 1'b1;
            if (!modelSat[i]) modelCnt[i] = modelMod[i] - 1;
          end else modelCnt[i] = modelCnt[i] - 1;
        end
      end
      e.cnt[i] = 8'(modelCnt[i]);
      e.tc[i]  = s.up ? (modelCnt[i] == modelMod[i] - 1) : (modelCnt[i] == 0);
    end
    if (s.rst) begin
      modelSync1 = 1'b0; modelSync2 = 1'b0; modelPrev = 1'b0;
    end else begin
      modelPrev  = modelSync2;
      modelSync2 = modelSync1;
      modelSync1 = s.step;
    end
  endtask

  task automatic check(input string name, input int actual, input int required);
    assertCount++;
    if (actual != required) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [2:0][7:0] cnt;
    logic [2:0]      wr, tc;
    cnt = {{4'd0, countF}, countS, countW};
    wr  = {wrapF, wrapS, wrapW};
    tc  = {tcF, tcS, tcW};
    assertCount++;
    if (scoreboard.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, required 1");
      return;
    end
    e = scoreboard.pop_front();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("count[%0d]", i), int'(cnt[i]), int'(e.cnt[i]));
      check($sformatf("wrap[%0d]", i), int'(wr[i]), int'(e.wrap[i]));
      check($sformatf("tc[%0d]", i), int'(tc[i]), int'(e.tc[i]));
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst = s.rst; en = s.en; step = s.step; up = s.up; load = s.load; lv = s.lv;
    modelEdge(s, e);
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    vec_t vecs [17];
    int   start;
    int   wrapSeen;

    // rst, en, step, up, load, lv -> expected dutWrap count, wrap (level-step build)
    vecs[0]  = '{mk(1, 1, 1, 1, 0, 8'd0),   8'd0, 1'b0};
    vecs[1]  = '{mk(0, 1, 1, 1, 0, 8'd0),   8'd1, 1'b0};
    vecs[2]  = '{mk(0, 1, 1, 1, 0, 8'd0),   8'd2, 1'b0};
    vecs[3]  = '{mk(0, 1, 1, 1, 0, 8'd0),   8'd3, 1'b0};
    vecs[4]  = '{mk(0, 1, 1, 1, 0, 8'd0),   8'd4, 1'b0};
    vecs[5]  = '{mk(0, 1, 1, 1, 0, 8'd0),   8'd5, 1'b0};
    vecs[6]  = '{mk(1, 1, 1, 1, 0, 8'd0),   8'd0, 1'b0};
    vecs[7]  = '{mk(0, 1, 1, 1, 0, 8'd0),   8'd1, 1'b0};
    vecs[8]  = '{mk(0, 0, 0, 1, 1, 8'd9),   8'd9, 1'b0};
    vecs[9]  = '{mk(0, 1, 1, 1, 0, 8'd0),   8'd0, 1'b1};
    vecs[10] = '{mk(0, 0, 0, 1, 0, 8'd0),   8'd0, 1'b0};
    vecs[11] = '{mk(0, 1, 1, 0, 0, 8'd0),   8'd9, 1'b1};
    vecs[12] = '{mk(0, 1, 1, 1, 1, 8'd200), 8'd9, 1'b0};
    vecs[13] = '{mk(0, 1, 1, 0, 0, 8'd0),   8'd8, 1'b0};
    vecs[14] = '{mk(0, 0, 1, 1, 0, 8'd0),   8'd8, 1'b0};
    vecs[15] = '{mk(0, 0, 0, 1, 1, 8'd0),   8'd0, 1'b0};
    vecs[16] = '{mk(0, 1, 1, 1, 0, 8'd0),   8'd1, 1'b0};

    $display("[TB] table vectors");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].s);
`ifndef STEP_EDGE_DETECT_EN
      check($sformatf("vec%0d_count", i), int'(countW), int'(vecs[i].expCount));
      check($sformatf("vec%0d_wrap", i), int'(wrapW), int'(vecs[i].expWrap));
`endif
    end

    $display("[TB] enable gating");
    for (int i = 0; i < 20; i++) applyStimulus(mk(0, 0, i[0], 1, 0, 8'd0));
    for (int i = 0; i < 4; i++)  applyStimulus(mk(0, 0, 0, 1, 0, 8'd0));
    start = modelCnt[0];
    for (int p = 0; p < 4; p++) begin
      applyStimulus(mk(0, 1, 1, 1, 0, 8'd0));
      for (int i = 0; i < 3; i++) applyStimulus(mk(0, 1, 0, 1, 0, 8'd0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(mk(0, 1, 0, 1, 0, 8'd0));
    check("gating_plus4", int'(countW), (start + 4) % 10);

    $display("[TB] saturate at zero");
    applyStimulus(mk(0, 0, 0, 0, 1, 8'd0));
    wrapSeen = 0;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(mk(0, 1, 1, 0, 0, 8'd0));
      wrapSeen += int'(wrapS);
      for (int i = 0; i < 3; i++) begin
        applyStimulus(mk(0, 1, 0, 0, 0, 8'd0));
        wrapSeen += int'(wrapS);
      end
    end
    check("sat_hold_zero", int'(countS), 0);
    check("sat_wrap_pulses", wrapSeen, 3);

    $display("[TB] held step");
    applyStimulus(mk(0, 0, 0, 1, 1, 8'd0));
    for (int i = 0; i < 50; i++) applyStimulus(mk(0, 1, 1, 1, 0, 8'd0));
    for (int i = 0; i < 4; i++)  applyStimulus(mk(0, 1, 0, 1, 0, 8'd0));
    check("held_mod10", int'(countW), HELD_INCS % 10);
    check("held_mod16", int'(countF), HELD_INCS % 16);

    $display("[TB] full-range modulus");
    applyStimulus(mk(0, 0, 0, 1, 1, 8'd255));
    check("full_load_clamp", int'(countF), 15);
    check("full_tc_top", int'(tcF), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
